vga_sync_generator: RTL

- Downstream stage of the horizontal pixel counter. Consumes its h_count_value (0..799) and its end-of-line pulse enable_v_counter.
- Maintains the vertical line counter (0..524) and a vertical-region FSM.
- Produces registered, mutually aligned hsync/vsync, video_active, pixel coordinates and frame/line strobes for the 640x480@60 pixel pipeline.

---
 rtl/vga_sync_generator.sv | 108 ++++++++++
 1 files changed

// File: rtl/vga_sync_generator.sv
// Vertical stage of the 640x480@60 timing chain: line counter, vertical-region FSM and
// registered sync/video/coordinate outputs, all one cycle behind h_count_value.
module vga_sync_generator #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [9:0] h_count_value,
    input  logic       enable_v_counter,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] pixel_x,
    output logic [8:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        StVAct,
        StVFp,
        StVSync,
        StVBp
    } v_state_e;

    v_state_e   state_q, state_d, line_region;
    logic [9:0] next_line;
    logic       advance;
    logic       h_vis, h_sync_on;

    always_comb begin
        next_line = v_count;
        advance   = enable_v_counter;
        if (v_count > V_LAST) begin
            // Out-of-range count is forced back to the top of the frame.
            next_line = '0;
            advance   = 1'b1;
        end else if (enable_v_counter) begin
            next_line = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end

        if (next_line < V_FP_START) begin
            line_region = StVAct;
        end else if (next_line < V_SYNC_START) begin
            line_region = StVFp;
        end else if (next_line < V_BP_START) begin
            line_region = StVSync;
        end else begin
            line_region = StVBp;
        end

        // Recomputing from next_line on every advance resynchronises a corrupted state.
        state_d = advance ? line_region : state_q;

        // Values 800..1023 fall outside both windows and are treated as blanking.
        h_vis     = h_count_value < H_VIS_END;
        h_sync_on = (h_count_value >= H_SYNC_START) && (h_count_value < H_SYNC_END);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q      <= StVAct;
            v_count      <= '0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            video_active <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_count      <= next_line;
            hsync        <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            vsync        <= (state_d == StVSync) ? SYNC_POL : ~SYNC_POL;
            video_active <= h_vis && (state_d == StVAct);
            pixel_x      <= (h_vis && (state_d == StVAct)) ? h_count_value : 10'd0;
            pixel_y      <= (h_vis && (state_d == StVAct)) ? next_line[8:0] : 9'd0;
            line_start   <= (h_count_value == 10'd0);
            frame_start  <= (h_count_value == 10'd0) && (next_line == 10'd0);
        end
    end

    // H_TOTAL only documents the intended line length; the decode never needs it.
    logic unused_h_total;
    assign unused_h_total = (H_TOTAL == 0);

endmodule
